pifo_task_scheduler: RTL and testbench
======================================

Name: pifo_task_scheduler

Overview:
- Arbitrates the LEVEL per-port show-ahead TaskFIFOs onto the LEVEL RPU issue slots of the SRAM PIFO ring; drop-in replacement for the plain task distributor.
- Each op is routed to its tree's root slot r = tree_id % LEVEL.
- Per root slot: round-robin over FIFO ports, ring-occupancy back-pressure, and a per-tree cooldown that keeps a second op off a tree until the previous one has cleared the SRAM read/write window.

Parameters:
- PTW, 16, payload width
- MTW, 0, metadata width
- LEVEL, 4, ring levels = FIFO ports = RPU slots; power of two, >=2
- TREE_NUM, 4, number of virtual trees; power of two, >=LEVEL
- COOLDOWN, 8, minimum cycles between two issues to the same tree; >=1
- Derived: TNB = $clog2(TREE_NUM); LB = $clog2(LEVEL); EW = 1+TNB+PTW+MTW (entry width); CW = $clog2(COOLDOWN+1)

Ports:
- i_clk  in  1  clock
- i_arst_n  in  1  reset, asynchronous, active-low
- i_sched_en  in  1  global grant enable
- i_fifo_empty  in  LEVEL  per-port FIFO empty
- i_fifo_data  in  EW x [0:LEVEL-1]  FIFO head; {is_push, tree_id, data}
- o_fifo_pop  out  LEVEL  combinational pop to granted ports
- i_ring_busy  in  LEVEL  slot r is taken next cycle by an in-flight op from level r-1 (wraps)
- o_rpu_push  out  LEVEL  registered push issue per slot
- o_rpu_pop  out  LEVEL  registered pop issue per slot
- o_rpu_tree_id  out  TNB x [0:LEVEL-1]  issued tree id
- o_rpu_push_data  out  (PTW+MTW) x [0:LEVEL-1]  issued data; all-ones on pop or idle
- o_tree_blocked  out  TREE_NUM  bit t = cooldown[t] != 0

Behaviour:
- Port p requests slot r when !i_fifo_empty[p], head tree_id[LB-1:0]==r, cooldown[tree_id]==0, !i_ring_busy[r] and i_sched_en.
- Per slot r, one winner per cycle. Search starts at rr_ptr[r] and goes upward mod LEVEL. On grant, rr_ptr[r] <= winner+1 mod LEVEL; otherwise it holds.
- A port has one head, so grants across slots are disjoint. Several slots may grant in the same cycle.
- Grant in cycle c: o_fifo_pop[p]=1 in cycle c. o_rpu_push/o_rpu_pop[r], tree id and data are registered and appear for exactly one cycle at c+1.
- Issue latency is 1 cycle; sustained throughput is 1 op per slot per cycle.
- Cooldown: on grant of tree t, cooldown[t] <= COOLDOWN-1; every other non-zero counter decrements by 1.
- Earliest re-grant of the same tree is therefore c+COOLDOWN. COOLDOWN=1 gives no restriction.
- Same tree at two port heads in one cycle: both map to the same slot, only the round-robin winner issues, and the other waits out the cooldown.
- i_ring_busy[r] and i_sched_en=0 only mask grants. Registered outputs for blocked slots are 0 next cycle; counters and pointers keep running.
- An entry with is_push=0 issues a pop; o_rpu_push_data is then all-ones.
- Reset, including mid-operation: all outputs 0, o_rpu_push_data all-ones, rr_ptr all 0, cooldown all 0, no pop asserted. An in-flight issue is dropped.

Optional Feature:
- Macro PIFO_SCHED_STATS_EN.
- Defined: adds o_issue_cnt (32 x [0:LEVEL-1]), counting issues per slot, and o_stall_cnt (32 x [0:LEVEL-1]), counting cycles where slot r had a valid-mapped head blocked only by i_ring_busy[r].
- Both counters saturate at all-ones and reset to 0.
- Not defined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset: drive i_arst_n=0 mid-issue -> all issue outputs 0, o_rpu_push_data=all-ones, o_fifo_pop=0, o_tree_blocked=0 in the same cycle.
- Single push, LEVEL=4, COOLDOWN=8: port 2 head {1,tree 5,0x00AB} -> o_fifo_pop[2]=1 at c; o_rpu_push[1]=1, tree 5, data 0x00AB at c+1; o_tree_blocked[5]=1 over c+1..c+7.
- Round-robin: ports 0,1,3 heads for trees 0,4,8, all root slot 0, held valid -> slot 0 grants port 0 at c, port 1 at c+1, port 3 at c+2. Reload port 0 -> port 0 next.
- Ring busy: i_ring_busy[2]=1 for 5 cycles with tree 6 at port 0 -> no grant; grant in the first cycle busy drops, issue the cycle after.
- Cooldown: port 0 holds pop tree 3 then push tree 3 -> issues on slot 3 at c+1 and c+9.
- Parallel slots plus stats: trees 0,1,2,3 heads on ports 0-3 -> all four slots issue at c+1. With PIFO_SCHED_STATS_EN, each o_issue_cnt increments by 1.

Source files
------------

// File: rtl/pifo_task_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : pifo_task_scheduler
// Purpose  : Routes per-port TaskFIFO heads onto PIFO ring RPU slots with
//            round-robin, ring back-pressure and per-tree cooldown.
//            Optional per-slot statistics under PIFO_SCHED_STATS_EN.
// Revision : 1.0
// ============================================================================
module pifo_task_scheduler #(
    parameter int PTW      = 16,
    parameter int MTW      = 0,
    parameter int LEVEL    = 4,
    parameter int TREE_NUM = 4,
    parameter int COOLDOWN = 8
) (
    input  logic                                i_clk,
    input  logic                                i_arst_n,
    input  logic                                i_sched_en,
    input  logic [LEVEL-1:0]                    i_fifo_empty,
    input  logic [PTW+MTW+$clog2(TREE_NUM):0]   i_fifo_data [0:LEVEL-1],
    output logic [LEVEL-1:0]                    o_fifo_pop,
    input  logic [LEVEL-1:0]                    i_ring_busy,
    output logic [LEVEL-1:0]                    o_rpu_push,
    output logic [LEVEL-1:0]                    o_rpu_pop,
    output logic [$clog2(TREE_NUM)-1:0]         o_rpu_tree_id [0:LEVEL-1],
    output logic [PTW+MTW-1:0]                  o_rpu_push_data [0:LEVEL-1],
    output logic [TREE_NUM-1:0]                 o_tree_blocked
`ifdef PIFO_SCHED_STATS_EN
    ,
    output logic [31:0]                         o_issue_cnt [0:LEVEL-1],
    output logic [31:0]                         o_stall_cnt [0:LEVEL-1]
`endif
);

    localparam int TNB = $clog2(TREE_NUM);
    localparam int LB  = $clog2(LEVEL);
    localparam int DW  = PTW + MTW;
    localparam int EW  = 1 + TNB + DW;
    localparam int CW  = $clog2(COOLDOWN + 1);

    logic [CW-1:0]    cooldown  [TREE_NUM];
    logic [LB-1:0]    rr_ptr    [LEVEL];

    logic [TNB-1:0]   head_tree [LEVEL];
    logic [DW-1:0]    head_data [LEVEL];
    logic [LEVEL-1:0] head_push;
    logic [LEVEL-1:0] head_ok;
    logic [LEVEL-1:0] map_ok    [LEVEL];
    logic [LEVEL-1:0] grant     [LEVEL];
    logic [LB-1:0]    win       [LEVEL];
    logic [LEVEL-1:0] slot_gnt;
    logic [TREE_NUM-1:0] tree_gnt;
    logic [LB-1:0]    idx;

    // Head decode; reset also suppresses every request so no pop leaks out.
    always_comb begin
        for (int p = 0; p < LEVEL; p++) begin
            head_push[p] = i_fifo_data[p][EW-1];
            head_tree[p] = i_fifo_data[p][DW +: TNB];
            head_data[p] = i_fifo_data[p][DW-1:0];
            head_ok[p]   = i_arst_n & i_sched_en & ~i_fifo_empty[p]
                         & (cooldown[head_tree[p]] == '0);
        end
        for (int r = 0; r < LEVEL; r++) begin
            for (int p = 0; p < LEVEL; p++) begin
                map_ok[r][p] = head_ok[p] & (head_tree[p][LB-1:0] == LB'(r));
            end
        end
    end

    // Per-slot round-robin search starting at rr_ptr, wrapping mod LEVEL.
    always_comb begin
        idx = '0;
        for (int r = 0; r < LEVEL; r++) begin
            grant[r]    = '0;
            win[r]      = '0;
            slot_gnt[r] = 1'b0;
            for (int k = 0; k < LEVEL; k++) begin
                idx = rr_ptr[r] + LB'(k);
                if (!slot_gnt[r] && !i_ring_busy[r] && map_ok[r][idx]) begin
                    slot_gnt[r]   = 1'b1;
                    win[r]        = idx;
                    grant[r][idx] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        o_fifo_pop = '0;
        tree_gnt   = '0;
        for (int r = 0; r < LEVEL; r++) begin
            o_fifo_pop = o_fifo_pop | grant[r];
            if (slot_gnt[r]) begin
                tree_gnt[head_tree[win[r]]] = 1'b1;
            end
        end
        for (int t = 0; t < TREE_NUM; t++) begin
            o_tree_blocked[t] = (cooldown[t] != '0);
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            o_rpu_push <= '0;
            o_rpu_pop  <= '0;
            for (int r = 0; r < LEVEL; r++) begin
                o_rpu_tree_id[r]   <= '0;
                o_rpu_push_data[r] <= '1;
                rr_ptr[r]          <= '0;
            end
            for (int t = 0; t < TREE_NUM; t++) begin
                cooldown[t] <= '0;
            end
        end else begin
            for (int t = 0; t < TREE_NUM; t++) begin
                if (tree_gnt[t]) begin
                    cooldown[t] <= CW'(COOLDOWN - 1);
                end else if (cooldown[t] != '0) begin
                    cooldown[t] <= cooldown[t] - CW'(1);
                end
            end
            for (int r = 0; r < LEVEL; r++) begin
                o_rpu_push[r]      <= slot_gnt[r] & head_push[win[r]];
                o_rpu_pop[r]       <= slot_gnt[r] & ~head_push[win[r]];
                o_rpu_tree_id[r]   <= slot_gnt[r] ? head_tree[win[r]] : '0;
                o_rpu_push_data[r] <= (slot_gnt[r] && head_push[win[r]]) ?
                                      head_data[win[r]] : '1;
                if (slot_gnt[r]) begin
                    rr_ptr[r] <= win[r] + LB'(1);
                end
            end
        end
    end

`ifdef PIFO_SCHED_STATS_EN
    // A stall is a slot with an otherwise grantable head held off by the ring.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            for (int r = 0; r < LEVEL; r++) begin
                o_issue_cnt[r] <= '0;
                o_stall_cnt[r] <= '0;
            end
        end else begin
            for (int r = 0; r < LEVEL; r++) begin
                if (slot_gnt[r] && (o_issue_cnt[r] != '1)) begin
                    o_issue_cnt[r] <= o_issue_cnt[r] + 32'd1;
                end
                if (i_ring_busy[r] && (|map_ok[r]) && (o_stall_cnt[r] != '1)) begin
                    o_stall_cnt[r] <= o_stall_cnt[r] + 32'd1;
                end
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pifo_task_scheduler.sv
`default_nettype none
// Testbench for pifo_task_scheduler: cycle model of grant/cooldown rules plus
// directed scenarios with literal expectations.
module tb_pifo_task_scheduler;

    localparam int PTW = 16, MTW = 0, LEVEL = 4, TREE_NUM = 16, COOLDOWN = 8;
    localparam int TNB = 4, DW = 16, EW = 21;

    logic clk = 1'b0, arst_n = 1'b0, sched_en = 1'b0;
    logic [LEVEL-1:0] fifo_empty = '1, ring_busy = '0;
    logic [LEVEL-1:0] fifo_pop, rpu_push, rpu_pop;
    logic [EW-1:0]    fifo_data     [0:LEVEL-1];
    logic [TNB-1:0]   rpu_tree_id   [0:LEVEL-1];
    logic [DW-1:0]    rpu_push_data [0:LEVEL-1];
    logic [TREE_NUM-1:0] tree_blocked;
`ifdef PIFO_SCHED_STATS_EN
    logic [31:0] issue_cnt [0:LEVEL-1];
    logic [31:0] stall_cnt [0:LEVEL-1];
    logic [31:0] snap      [0:LEVEL-1];
`endif

    bit hd_push [LEVEL];
    int hd_tree [LEVEL];
    int hd_data [LEVEL];

    always_comb begin
        for (int p = 0; p < LEVEL; p++)
            fifo_data[p] = {hd_push[p], TNB'(hd_tree[p]), DW'(hd_data[p])};
    end

    pifo_task_scheduler #(
        .PTW(PTW), .MTW(MTW), .LEVEL(LEVEL), .TREE_NUM(TREE_NUM), .COOLDOWN(COOLDOWN)
    ) dut (
        .i_clk(clk), .i_arst_n(arst_n), .i_sched_en(sched_en),
        .i_fifo_empty(fifo_empty), .i_fifo_data(fifo_data), .o_fifo_pop(fifo_pop),
        .i_ring_busy(ring_busy), .o_rpu_push(rpu_push), .o_rpu_pop(rpu_pop),
        .o_rpu_tree_id(rpu_tree_id), .o_rpu_push_data(rpu_push_data),
        .o_tree_blocked(tree_blocked)
`ifdef PIFO_SCHED_STATS_EN
        , .o_issue_cnt(issue_cnt), .o_stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int  m_rr   [LEVEL];
    int  m_last [TREE_NUM];
    bit  m_has  [TREE_NUM];
    bit  e_push [LEVEL];
    bit  e_pop  [LEVEL];
    int  e_tree [LEVEL];
    int  e_data [LEVEL];
    int  m_icnt [LEVEL];
    int  m_scnt [LEVEL];
    int  cyc = 0;
    bit  blk    [TREE_NUM];
    logic [TREE_NUM-1:0] eb;
    logic [LEVEL-1:0]    ep;
    int  gnt, pp;
    bit  waiting;

    function automatic bit head_ready(int p, int r);
        return sched_en && !fifo_empty[p] && (hd_tree[p] % LEVEL == r) && !blk[hd_tree[p]];
    endfunction

    always @(negedge clk) begin
        if (!arst_n) begin
            for (int r = 0; r < LEVEL; r++) begin
                m_rr[r] = 0; e_push[r] = 0; e_pop[r] = 0; e_tree[r] = 0;
                e_data[r] = 'hFFFF; m_icnt[r] = 0; m_scnt[r] = 0;
                check("rst_tree_id", rpu_tree_id[r], 0);
                check("rst_data", rpu_push_data[r], 16'hFFFF);
`ifdef PIFO_SCHED_STATS_EN
                check("rst_issue_cnt", issue_cnt[r], 0);
                check("rst_stall_cnt", stall_cnt[r], 0);
`endif
            end
            for (int t = 0; t < TREE_NUM; t++) m_has[t] = 0;
            check("rst_push", rpu_push, 0);
            check("rst_pop", rpu_pop, 0);
            check("rst_fifo_pop", fifo_pop, 0);
            check("rst_blocked", tree_blocked, 0);
        end else begin
            for (int t = 0; t < TREE_NUM; t++) begin
                blk[t] = m_has[t] && ((cyc - m_last[t]) < COOLDOWN);
                eb[t]  = blk[t];
            end
            check("m_tree_blocked", tree_blocked, eb);
            for (int r = 0; r < LEVEL; r++) begin
                check("m_rpu_push", rpu_push[r], e_push[r]);
                check("m_rpu_pop", rpu_pop[r], e_pop[r]);
                check("m_tree_id", rpu_tree_id[r], e_tree[r]);
                check("m_push_data", rpu_push_data[r], e_data[r]);
`ifdef PIFO_SCHED_STATS_EN
                check("m_issue_cnt", issue_cnt[r], m_icnt[r]);
                check("m_stall_cnt", stall_cnt[r], m_scnt[r]);
`endif
            end
            ep = '0;
            for (int r = 0; r < LEVEL; r++) begin
                gnt = -1;
                waiting = 0;
                for (int k = 0; k < LEVEL; k++) begin
                    pp = (m_rr[r] + k) % LEVEL;
                    if (head_ready(pp, r)) begin
                        waiting = 1;
                        if (gnt < 0 && !ring_busy[r]) gnt = pp;
                    end
                end
                if (gnt >= 0) begin
                    ep[gnt]   = 1'b1;
                    e_push[r] = hd_push[gnt];
                    e_pop[r]  = !hd_push[gnt];
                    e_tree[r] = hd_tree[gnt];
                    e_data[r] = hd_push[gnt] ? hd_data[gnt] : 'hFFFF;
                    m_rr[r]   = (gnt + 1) % LEVEL;
                    m_has[hd_tree[gnt]]  = 1;
                    m_last[hd_tree[gnt]] = cyc;
                    m_icnt[r]++;
                end else begin
                    e_push[r] = 0; e_pop[r] = 0; e_tree[r] = 0; e_data[r] = 'hFFFF;
                    if (ring_busy[r] && waiting) m_scnt[r]++;
                end
            end
            check("m_fifo_pop", fifo_pop, ep);
            cyc++;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_head(input int p, input bit push, input int tree, input int data);
        hd_push[p] = push; hd_tree[p] = tree; hd_data[p] = data; fifo_empty[p] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int p = 0; p < LEVEL; p++) begin
            hd_push[p] = 0; hd_tree[p] = 0; hd_data[p] = 0;
        end
        repeat (2) tick();
        arst_n = 1'b1; sched_en = 1'b1;
        tick();

        // single push: port 2, tree 5 -> slot 1
        tick(); set_head(2, 1, 5, 'h00AB); #2;
        check("s1_pop", fifo_pop, 4'b0100);
        tick(); fifo_empty[2] = 1'b1; #2;
        check("s1_push", rpu_push, 4'b0010);
        check("s1_tree", rpu_tree_id[1], 5);
        check("s1_data", rpu_push_data[1], 16'h00AB);
        check("s1_blk", tree_blocked[5], 1);
        for (int k = 2; k <= 7; k++) begin
            tick(); #2; check("s1_blk_hold", tree_blocked[5], 1);
        end
        tick(); #2; check("s1_blk_end", tree_blocked[5], 0);

        // round-robin on slot 0
        tick(); set_head(0, 1, 0, 'h10); set_head(1, 1, 4, 'h14); set_head(3, 1, 8, 'h18); #2;
        check("s2_pop0", fifo_pop, 4'b0001);
        tick(); #2;
        check("s2_pop1", fifo_pop, 4'b0010);
        check("s2_iss0", rpu_tree_id[0], 0);
        tick(); #2;
        check("s2_pop3", fifo_pop, 4'b1000);
        check("s2_iss1", rpu_tree_id[0], 4);
        tick(); set_head(0, 1, 12, 'h1C); #2;
        check("s2_reload", fifo_pop, 4'b0001);
        check("s2_iss3", rpu_tree_id[0], 8);
        tick(); fifo_empty = '1; #2;
        check("s2_iss_reload", rpu_tree_id[0], 12);
        check("s2_data", rpu_push_data[0], 16'h001C);

        // ring busy on slot 2
        tick(); ring_busy[2] = 1'b1; set_head(0, 1, 6, 'h0606); #2;
`ifdef PIFO_SCHED_STATS_EN
        snap[2] = stall_cnt[2];
`endif
        check("s3_busy_pop", fifo_pop, 0);
        repeat (4) begin
            tick(); #2; check("s3_busy_pop", fifo_pop, 0);
        end
        tick(); ring_busy[2] = 1'b0; #2;
        check("s3_release_pop", fifo_pop, 4'b0001);
`ifdef PIFO_SCHED_STATS_EN
        check("s3_stall_cnt", stall_cnt[2], snap[2] + 5);
`endif
        tick(); fifo_empty[0] = 1'b1; #2;
        check("s3_push", rpu_push, 4'b0100);
        check("s3_tree", rpu_tree_id[2], 6);

        // cooldown: pop then push on tree 3
        tick(); set_head(0, 0, 3, 'h3333); #2;
        check("s4_pop_c", fifo_pop, 4'b0001);
        tick(); set_head(0, 1, 3, 'h1234); #2;
        check("s4_rpu_pop", rpu_pop, 4'b1000);
        check("s4_rpu_push", rpu_push, 0);
        check("s4_pop_data", rpu_push_data[3], 16'hFFFF);
        check("s4_pop_tree", rpu_tree_id[3], 3);
        check("s4_hold1", fifo_pop, 0);
        for (int k = 2; k <= 7; k++) begin
            tick(); #2; check("s4_hold", fifo_pop, 0);
        end
        tick(); #2; check("s4_regrant", fifo_pop, 4'b0001);
        tick(); fifo_empty[0] = 1'b1; #2;
        check("s4_push", rpu_push, 4'b1000);
        check("s4_push_data", rpu_push_data[3], 16'h1234);

        // parallel slots, first masked by sched_en
        repeat (COOLDOWN) tick();
        sched_en = 1'b0;
        for (int p = 0; p < LEVEL; p++) set_head(p, 1, p, 'h100 * (p + 1));
        #2; check("s5_disabled", fifo_pop, 0);
        tick(); sched_en = 1'b1; #2;
        check("s5_pop_all", fifo_pop, 4'b1111);
`ifdef PIFO_SCHED_STATS_EN
        for (int r = 0; r < LEVEL; r++) snap[r] = issue_cnt[r];
`endif
        tick(); fifo_empty = '1; #2;
        check("s5_push_all", rpu_push, 4'b1111);
        for (int r = 0; r < LEVEL; r++) begin
            check("s5_tree", rpu_tree_id[r], r);
            check("s5_data", rpu_push_data[r], 'h100 * (r + 1));
`ifdef PIFO_SCHED_STATS_EN
            check("s5_issue_cnt", issue_cnt[r], snap[r] + 1);
`endif
        end

        // reset mid-issue
        tick();
        for (int p = 0; p < LEVEL; p++) set_head(p, 1, p + 4, 'h40 + p);
        #2; check("s6_pop", fifo_pop, 4'b1111);
        tick(); #1;
        check("s6_issue", rpu_push, 4'b1111);
        arst_n = 1'b0; #1;
        check("s6_rst_push", rpu_push, 0);
        check("s6_rst_data", rpu_push_data[1], 16'hFFFF);
        check("s6_rst_fifo_pop", fifo_pop, 0);
        check("s6_rst_blocked", tree_blocked, 0);
        tick(); arst_n = 1'b1; fifo_empty = '1;
        repeat (3) tick();
        #2; check("s6_idle", rpu_push | rpu_pop, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
